// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
// Optional retire counter is enabled by defining SEQ_RETIRE_CNT_EN.
package seq_pkg;

   localparam int DEF_ADDR_W = 7;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_AMP_W  = 8;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 28;
   localparam int CH_BIT   = 27;
   localparam int OPND_MSB = 7;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_PLAY = 4'd1,
      OP_WAIT = 4'd2,
      OP_JUMP = 4'd3,
      OP_HALT = 4'd4
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_WAIT,
      S_HALTED
   } state_e;

endpackage

// File: rtl/seq_wait_timer.sv
// Loadable down-counter with zero flag for the WAIT state.
// Counter holds at zero; load takes priority over decrement.
module seq_wait_timer
   import seq_pkg::*;
#(
   parameter int W = DEF_AMP_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   // count register: load on entry, step down while waiting
   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (dec && (cnt_q != '0))
         cnt_q <= cnt_q - 1'b1;
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer driving per-channel amplitudes.
// Define SEQ_RETIRE_CNT_EN to add the retired_cnt output.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int                ADDR_W     = DEF_ADDR_W,
   parameter int                DATA_W     = DEF_DATA_W,
   parameter int                AMP_W      = DEF_AMP_W,
   parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] instr,
   output logic [AMP_W-1:0]  ch0_amp,
   output logic [AMP_W-1:0]  ch1_amp,
   output logic [1:0]        amp_stb,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef SEQ_RETIRE_CNT_EN
   ,
   output logic [15:0]       retired_cnt
`endif
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_d;
   logic [AMP_W-1:0]  ch0_d, ch1_d;
   logic [1:0]        stb_d;
   logic              done_d, err_d;
   logic              ld, dec, zero;
   logic              retire, clr;

   logic [3:0]        opc;
   logic              ch;
   logic [AMP_W-1:0]  opnd;
   logic              unused_bits;

   assign opc  = instr[OPC_MSB:OPC_LSB];
   assign ch   = instr[CH_BIT];
   assign opnd = instr[OPND_MSB -: AMP_W];
   assign unused_bits = ^instr[CH_BIT-1:OPND_MSB+1];

   assign busy = (state_q == S_FETCH) ||
                 (state_q == S_EXEC)  ||
                 (state_q == S_WAIT);

   seq_wait_timer #(.W(AMP_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .dec      (dec),
      .load_val (opnd - 1'b1),
      .zero     (zero)
   );

   // next-state and datapath decode
   always_comb begin
      state_d = state_q;
      pc_d    = addr;
      ch0_d   = ch0_amp;
      ch1_d   = ch1_amp;
      stb_d   = '0;
      done_d  = done;
      err_d   = err;
      ld      = 1'b0;
      dec     = 1'b0;
      retire  = 1'b0;
      clr     = 1'b0;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (start) begin
               pc_d    = START_ADDR;
               done_d  = 1'b0;
               err_d   = 1'b0;
               clr     = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_EXEC;
         S_EXEC: begin
            retire  = 1'b1;
            state_d = S_FETCH;
            pc_d    = addr + 1'b1;
            case (opc)
               OP_NOP: ;
               OP_PLAY: begin
                  stb_d[ch] = 1'b1;
                  if (ch) ch1_d = opnd;
                  else    ch0_d = opnd;
               end
               OP_WAIT: begin
                  if (opnd != '0) begin
                     ld      = 1'b1;
                     state_d = S_WAIT;
                  end
               end
               OP_JUMP: pc_d = instr[ADDR_W-1:0];
               OP_HALT: begin
                  pc_d    = addr;
                  done_d  = 1'b1;
                  state_d = S_HALTED;
               end
               default: begin
                  retire  = 1'b0;
                  pc_d    = addr;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = S_HALTED;
               end
            endcase
         end
         S_WAIT: begin
            if (zero) state_d = S_FETCH;
            else      dec     = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state, pc and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr    <= START_ADDR;
         ch0_amp <= '0;
         ch1_amp <= '0;
         amp_stb <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         addr    <= pc_d;
         ch0_amp <= ch0_d;
         ch1_amp <= ch1_d;
         amp_stb <= stb_d;
         done    <= done_d;
         err     <= err_d;
      end
   end

`ifdef SEQ_RETIRE_CNT_EN
   // saturating count of legally executed instructions
   always_ff @(posedge clk) begin
      if (rst || clr)
         retired_cnt <= '0;
      else if (retire && (retired_cnt != 16'hFFFF))
         retired_cnt <= retired_cnt + 16'd1;
   end
`else
   logic unused_retire;
   assign unused_retire = retire ^ clr ^ unused_bits;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer with a program-level model.
// Retire counter checks compile in when SEQ_RETIRE_CNT_EN is defined.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [6:0]  addr;
   logic [31:0] instr;
   logic [7:0]  ch0_amp, ch1_amp;
   logic [1:0]  amp_stb;
   logic        busy, done, err;
`ifdef SEQ_RETIRE_CNT_EN
   logic [15:0] retired_cnt;
`endif

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [128];

   // model results
   logic [1:0]  exp_stb [512];
   logic [7:0]  exp_ch0 = 8'h00, exp_ch1 = 8'h00;
   logic [7:0]  m_a0, m_a1;
   logic [6:0]  m_pc;
   int          m_tend, m_ret;
   bit          m_ok, m_err;

   always #5 clk = ~clk;

   // synchronous instruction memory
   always @(posedge clk) instr <= mem[addr];

   instr_sequencer dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .addr    (addr),
      .instr   (instr),
      .ch0_amp (ch0_amp),
      .ch1_amp (ch1_amp),
      .amp_stb (amp_stb),
      .busy    (busy),
      .done    (done),
      .err     (err)
`ifdef SEQ_RETIRE_CNT_EN
      ,
      .retired_cnt (retired_cnt)
`endif
   );

   function automatic logic [31:0] mk(int op, int ch, int opnd);
      logic [3:0] o;
      logic [7:0] v;
      logic       c;
      o = op[3:0];
      v = opnd[7:0];
      c = ch[0];
      return {o, c, 19'd0, v};
   endfunction

   // Executes the program instruction by instruction, accumulating
   // cycle time: 2 per instruction, plus N for WAIT N.
   task automatic model_run();
      logic [6:0]  pc;
      logic [31:0] w;
      logic [7:0]  a0, a1;
      int t, op, n;
      a0 = exp_ch0;
      a1 = exp_ch1;
      for (int i = 0; i < 512; i++) exp_stb[i] = 2'b00;
      pc = 7'd0;
      t = 0;
      m_ok = 0;
      m_err = 0;
      m_ret = 0;
      while (!m_ok && t < 400) begin
         w = mem[pc];
         op = int'(w[31:28]);
         n = int'(w[7:0]);
         if (op == 0) begin
            m_ret++; t += 2; pc++;
         end else if (op == 1) begin
            if (w[27]) a1 = w[7:0];
            else       a0 = w[7:0];
            exp_stb[t+2][w[27]] = 1'b1;
            m_ret++; t += 2; pc++;
         end else if (op == 2) begin
            m_ret++; t += 2 + n; pc++;
         end else if (op == 3) begin
            m_ret++; t += 2; pc = w[6:0];
         end else if (op == 4) begin
            m_ret++; m_tend = t + 2; m_pc = pc; m_ok = 1;
         end else begin
            m_err = 1; m_tend = t + 2; m_pc = pc; m_ok = 1;
         end
      end
      m_a0 = a0;
      m_a1 = a1;
   endtask

   // Run the loaded program from start and compare against the model.
   task automatic run_prog(string name, bit pulses);
      int stb_bad, busy_bad;
      logic d0, e0;
      model_run();
      checks++;
      if (!m_ok) begin
         failures++;
         $display("FAIL %s.model_halt got=0 required=1", name);
         return;
      end
      stb_bad = 0;
      busy_bad = 0;
      @(negedge clk);
      start = 1'b1;
      for (int k = 0; k < m_tend + 2; k++) begin
         @(negedge clk);
         if (k == 0) begin
            d0 = done;
            e0 = err;
         end
         if (amp_stb !== exp_stb[k]) stb_bad++;
         if (busy !== (k < m_tend)) busy_bad++;
         start = pulses && (k < m_tend) &&
                 ($urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      checks++;
      if (d0 !== 1'b0 || e0 !== 1'b0) begin
         failures++;
         $display("FAIL %s.start_clear done=%b err=%b required=0/0",
                  name, d0, e0);
      end
      checks++;
      if (stb_bad != 0) begin
         failures++;
         $display("FAIL %s.amp_stb bad_cycles=%0d required=0",
                  name, stb_bad);
      end
      checks++;
      if (busy_bad != 0) begin
         failures++;
         $display("FAIL %s.busy bad_cycles=%0d required=0 (len %0d)",
                  name, busy_bad, m_tend);
      end
      checks++;
      if (done !== 1'b1 || err !== m_err) begin
         failures++;
         $display("FAIL %s.done_err got=%b/%b required=1/%b",
                  name, done, err, m_err);
      end
      checks++;
      if (ch0_amp !== m_a0 || ch1_amp !== m_a1) begin
         failures++;
         $display("FAIL %s.amps got=%h/%h required=%h/%h",
                  name, ch0_amp, ch1_amp, m_a0, m_a1);
      end
      if (!m_err) begin
         checks++;
         if (addr !== m_pc) begin
            failures++;
            $display("FAIL %s.addr got=%0d required=%0d",
                     name, addr, m_pc);
         end
      end
`ifdef SEQ_RETIRE_CNT_EN
      checks++;
      if (retired_cnt !== 16'(m_ret)) begin
         failures++;
         $display("FAIL %s.retired got=%0d required=%0d",
                  name, retired_cnt, m_ret);
      end
`endif
      exp_ch0 = m_a0;
      exp_ch1 = m_a1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 128; i++) mem[i] = 32'd0;
   endtask

   task automatic check_idle(string name);
      checks++;
      if (addr !== 7'd0 || ch0_amp !== 8'd0 || ch1_amp !== 8'd0 ||
          amp_stb !== 2'b00 || busy !== 1'b0 ||
          done !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL %s got addr=%0d amps=%h/%h stb=%b b/d/e=%b%b%b required 0 everywhere",
                  name, addr, ch0_amp, ch1_amp, amp_stb, busy, done, err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      exp_ch0 = 8'h00;
      exp_ch1 = 8'h00;
      @(negedge clk);
      check_idle("reset_hold");
   endtask

   task automatic test_play_halt();
      clear_mem();
      mem[0] = mk(1, 0, 8'h40);
      mem[1] = mk(1, 1, 8'h80);
      mem[2] = mk(4, 0, 0);
      run_prog("play_halt", 0);
   endtask

   task automatic test_wait();
      clear_mem();
      mem[0] = mk(2, 1, 5);
      mem[1] = mk(4, 0, 0);
      run_prog("wait5", 0);
      mem[0] = mk(2, 0, 0);
      run_prog("wait0", 0);
   endtask

   task automatic test_illegal();
      clear_mem();
      mem[0] = mk(10, $urandom_range(0, 1), $urandom_range(0, 255));
      run_prog("illegal", 0);
      mem[0] = mk(4, 0, 0);
      run_prog("restart_after_err", 0);
   endtask

   task automatic test_wrap();
      logic [6:0] prev;
      bit wrapped;
      clear_mem();
      for (int i = 0; i < 128; i++)
         mem[i] = mk(0, $urandom_range(0, 1), $urandom_range(0, 255));
      wrapped = 0;
      prev = 7'd0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 400 && !wrapped; k++) begin
         @(negedge clk);
         if (prev == 7'd127 && addr == 7'd0) wrapped = 1;
         prev = addr;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (!wrapped || err !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL wrap wrapped=%0d err=%b busy=%b required=1/0/1",
                  wrapped, err, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_ch0 = 8'h00;
      exp_ch1 = 8'h00;
   endtask

   task automatic test_jump_reset();
      int bad;
      clear_mem();
      mem[0]   = mk(1, 0, 8'h55);
      mem[1]   = mk(1, 1, 8'h66);
      mem[2]   = mk(3, 1, 127);
      mem[127] = mk(3, 0, 8'h7F);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (ch0_amp !== 8'h55 || ch1_amp !== 8'h66 || busy !== 1'b1) begin
         failures++;
         $display("FAIL selfloop amps=%h/%h busy=%b required=55/66/1",
                  ch0_amp, ch1_amp, busy);
      end
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      exp_ch0 = 8'h00;
      exp_ch1 = 8'h00;
      check_idle("rst_midrun");
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy !== 1'b0 || amp_stb !== 2'b00) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL rst_after bad_cycles=%0d required=0", bad);
      end
   endtask

   task automatic gen_random();
      int r, op, opnd;
      for (int tries = 0; tries < 50; tries++) begin
         for (int a = 0; a < 128; a++) begin
            r = $urandom_range(0, 99);
            opnd = $urandom_range(0, 255);
            if (r < 30)      op = 0;
            else if (r < 55) op = 1;
            else if (r < 70) begin op = 2; opnd = $urandom_range(0, 6); end
            else if (r < 78) op = 3;
            else if (r < 93) op = 4;
            else             op = $urandom_range(5, 15);
            mem[a] = mk(op, $urandom_range(0, 1), opnd);
         end
         model_run();
         if (m_ok && m_tend > 6) break;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         gen_random();
         run_prog($sformatf("random%0d", i), 1);
      end
   endtask

   task automatic test_back_to_back();
      clear_mem();
      mem[0] = mk(1, 1, 8'hA5);
      mem[1] = mk(1, 1, 8'h5A);
      mem[2] = mk(1, 0, 8'h11);
      mem[3] = mk(4, 1, 8'hFF);
      run_prog("b2b_play", 1);
   endtask

`ifdef SEQ_RETIRE_CNT_EN
   task automatic test_retire();
      clear_mem();
      mem[3] = mk(4, 0, 0);
      run_prog("retire_nops", 1);
   endtask
`endif

   initial begin
      rst = 1'b1;
      start = 1'b0;
      clear_mem();
      test_reset();
      test_play_halt();
      test_wait();
      test_illegal();
      test_back_to_back();
      test_wrap();
      test_jump_reset();
      test_random();
`ifdef SEQ_RETIRE_CNT_EN
      test_retire();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
